opc_boot_loader: RTL

Boot sequencer and memory-bus owner for the OPC 8-bit CPU. It holds the CPU in reset and streams a program image, delivered one byte at a time over a valid/ready handshake, into RAM starting at the CPU reset vector. When the load completes it releases the CPU's reset and hands the 11-bit memory bus to the CPU. It sits between the CPU, the program RAM and the host/loader byte source.

---
 rtl/opc_pkg.sv | 33 +++
 rtl/opc_bus_mux.sv | 29 ++
 rtl/opc_boot_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/opc_pkg.sv
// Shared types and constants for the OPC boot loader.
// States CSUM/ERROR exist only when OPC_LOADER_CHECKSUM_EN is defined.
package opc_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] LOAD_BASE_DEFAULT = 11'h100;

`ifdef OPC_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_CSUM  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3
    } state_t;
`endif

    // Image addresses wrap at the bus width, so a long image folds back to 0.
    function automatic logic [ADDR_W-1:0] load_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] count);
        return base + count;
    endfunction

endpackage

// File: rtl/opc_bus_mux.sv
// Combinational memory-bus owner select: CPU when i_owner_cpu, loader otherwise.
module opc_bus_mux
    import opc_pkg::*;
(
    input  logic              i_owner_cpu,
    input  logic [ADDR_W-1:0] i_ldr_address,
    input  logic              i_ldr_rnw,
    input  logic [DATA_W-1:0] i_ldr_wdata,
    input  logic [ADDR_W-1:0] i_cpu_address,
    input  logic              i_cpu_rnw,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_rnw,
    output logic [DATA_W-1:0] o_mem_wdata
);

    always_comb begin
        if (i_owner_cpu) begin
            o_mem_address = i_cpu_address;
            o_mem_rnw     = i_cpu_rnw;
            o_mem_wdata   = i_cpu_wdata;
        end else begin
            o_mem_address = i_ldr_address;
            o_mem_rnw     = i_ldr_rnw;
            o_mem_wdata   = i_ldr_wdata;
        end
    end

endmodule

// File: rtl/opc_boot_loader.sv
// Boot sequencer: streams an image into RAM at LOAD_BASE, then releases the CPU.
// Optional checksum byte and ERROR state enabled by OPC_LOADER_CHECKSUM_EN.
module opc_boot_loader
    import opc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LOAD_BASE = LOAD_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cpu_reset_b,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_rnw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_rnw,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              err
);

    state_t            r_state;
    state_t            w_next_state;
    state_t            w_start_target;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_byte;
    logic              r_cpu_reset_b;
    logic              w_load_start;
    logic              w_ldr_rnw;
    logic              w_in_ready;
    logic              w_busy;
    logic              w_last_byte;

`ifdef OPC_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    // An empty image still goes through the checksum step, expecting 0.
    assign w_start_target = (len != '0) ? ST_LOAD : ST_CSUM;
    assign err            = (r_state == ST_ERROR);
`else
    assign w_start_target = (len != '0) ? ST_LOAD : ST_RUN;
    assign err            = 1'b0;
`endif

    assign w_last_byte = ((r_count + 11'd1) == r_len);

    always_comb begin
        w_next_state = r_state;
        w_load_start = 1'b0;
        w_ldr_rnw    = 1'b1;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    w_load_start = 1'b1;
                    w_next_state = w_start_target;
                end
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_ldr_rnw = 1'b0;
                w_busy    = 1'b1;
                if (w_last_byte) begin
`ifdef OPC_LOADER_CHECKSUM_EN
                    w_next_state = ST_CSUM;
`else
                    w_next_state = ST_RUN;
`endif
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
`ifdef OPC_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (in_valid) begin
                    w_next_state = (in_data == r_sum) ? ST_RUN : ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (start) begin
                    w_load_start = 1'b1;
                    w_next_state = w_start_target;
                end
            end
`endif
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_count       <= '0;
            r_byte        <= '0;
            r_cpu_reset_b <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            // Registered release: the CPU and bus ownership change on the same edge.
            r_cpu_reset_b <= (w_next_state == ST_RUN);
            if (w_load_start) begin
                r_len   <= len;
                r_count <= '0;
            end else if (r_state == ST_WRITE) begin
                r_count <= r_count + 11'd1;
            end
            if ((r_state == ST_LOAD) && in_valid) begin
                r_byte <= in_data;
            end
        end
    end

`ifdef OPC_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_sum <= '0;
        end else if (w_load_start) begin
            r_sum <= '0;
        end else if (r_state == ST_WRITE) begin
            r_sum <= r_sum + r_byte;
        end
    end
`endif

    assign in_ready    = w_in_ready;
    assign busy        = w_busy;
    assign cpu_reset_b = r_cpu_reset_b;

    opc_bus_mux u_bus_mux (
        .i_owner_cpu   (r_state == ST_RUN),
        .i_ldr_address (load_addr(LOAD_BASE, r_count)),
        .i_ldr_rnw     (w_ldr_rnw),
        .i_ldr_wdata   (r_byte),
        .i_cpu_address (cpu_address),
        .i_cpu_rnw     (cpu_rnw),
        .i_cpu_wdata   (cpu_wdata),
        .o_mem_address (mem_address),
        .o_mem_rnw     (mem_rnw),
        .o_mem_wdata   (mem_wdata)
    );

endmodule
